alu_seq_unit: RTL

Parametrised successor of the accumulator ALU subsystem: operand-A/B source muxes, a combinational single-cycle ALU, and a registered ALU result. Adds multi-cycle shift-left and multiply with a start/busy/done handshake, plus registered zero/carry/overflow flags. Sits in the datapath between the architectural registers (PC, ACC, SP, MDR) and the immediate-extension units; the control FSM starts operations and reads `aluOut` once `Done` is seen.

---
 rtl/alu_seq_unit_if.sv | 34 +++
 rtl/alu_seq_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - operand/select/result bundle between control FSM and alu_seq_unit
// The control side is the master; the ALU is the slave.
interface alu_seq_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sp;
  logic [WIDTH-1:0] mdr;
  logic [WIDTH-1:0] se;
  logic [WIDTH-1:0] ze;
  logic [WIDTH-1:0] sl1;
  logic [1:0]       src_a;
  logic [2:0]       src_b;
  logic [2:0]       alu_op;
  logic             start;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] alu_out;
  logic             busy;
  logic             done;
  logic             zero;
  logic             carry;
  logic             ovf;

  modport master (
    output pc, acc, sp, mdr, se, ze, sl1, src_a, src_b, alu_op, start,
    input  out, alu_out, busy, done, zero, carry, ovf
  );

  modport slave (
    input  pc, acc, sp, mdr, se, ze, sl1, src_a, src_b, alu_op, start,
    output out, alu_out, busy, done, zero, carry, ovf
  );
endinterface

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - operand muxes, single-cycle ALU, iterative SLL/MUL, registered result and flags
// Define ALU_MUL_EN to build the iterative multiplier; otherwise op 7 completes in one cycle with result 0.
module alu_seq_unit #(
  parameter int WIDTH = 16,
  parameter int INC   = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  alu_seq_unit_if.slave io_alu
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_done;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SW-1:0]    w_n;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_out;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH-1:0] w_single_res;
  logic             w_iter;
  logic             w_last;
  logic [WIDTH-1:0] w_iter_res;
  logic             w_iter_ovf;

  always_comb begin
    w_a = '0;
    case (io_alu.src_a)
      2'd0:    w_a = io_alu.pc;
      2'd1:    w_a = io_alu.acc;
      2'd2:    w_a = io_alu.sp;
      default: w_a = '0;
    endcase
  end

  always_comb begin
    w_b = '0;
    case (io_alu.src_b)
      3'd0:    w_b = WIDTH'(INC);
      3'd1:    w_b = io_alu.se;
      3'd2:    w_b = io_alu.mdr;
      3'd3:    w_b = io_alu.ze;
      3'd4:    w_b = io_alu.sl1;
      default: w_b = '0;
    endcase
  end

  assign w_n    = w_b[SW-1:0];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  // SUB carry out is the inverted borrow.
  assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + (WIDTH+1)'(1);

  always_comb begin
    w_out   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (io_alu.alu_op)
      OP_ADD: begin
        w_out   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_out   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND:  w_out = w_a & w_b;
      OP_OR:   w_out = w_a | w_b;
      OP_XOR:  w_out = w_a ^ w_b;
      OP_SLT:  w_out = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      default: w_out = '0;
    endcase
  end

  // A zero-length shift completes in one cycle and passes A through.
  assign w_single_res = (io_alu.alu_op == OP_SLL) ? w_a : w_out;
  assign w_last       = (r_cnt == CW'(1));

`ifdef ALU_MUL_EN
  logic               r_is_mul;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_iter = io_alu.start &&
                  (((io_alu.alu_op == OP_SLL) && (|w_n)) || (io_alu.alu_op == OP_MUL));
  // Right-shifting shift-add: high half accumulates, low half holds the remaining multiplier bits.
  assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_sh} : '0);
  assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_iter_res  = r_is_mul ? w_prod_next[WIDTH-1:0] : {r_sh[WIDTH-2:0], 1'b0};
  assign w_iter_ovf  = r_is_mul && (|w_prod_next[2*WIDTH-1:WIDTH]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_is_mul <= 1'b0;
      r_prod   <= '0;
    end else if (r_state == S_IDLE && w_iter) begin
      r_is_mul <= (io_alu.alu_op == OP_MUL);
      r_prod   <= {{WIDTH{1'b0}}, w_b};
    end else if (r_state == S_BUSY && r_is_mul) begin
      r_prod   <= w_prod_next;
    end
  end
`else
  logic r_is_mul;

  assign r_is_mul   = 1'b0;
  assign w_iter     = io_alu.start && (io_alu.alu_op == OP_SLL) && (|w_n);
  assign w_iter_res = {r_sh[WIDTH-2:0], 1'b0};
  assign w_iter_ovf = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_iter) w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    io_alu.busy    = (r_state == S_BUSY);
    io_alu.out     = w_out;
    io_alu.alu_out = r_alu_out;
    io_alu.done    = r_done;
    io_alu.zero    = r_zero;
    io_alu.carry   = r_carry;
    io_alu.ovf     = r_ovf;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_alu_out <= '0;
      r_done    <= 1'b0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_sh      <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_iter) begin
          r_sh  <= w_a;
          r_cnt <= (io_alu.alu_op == OP_SLL) ? {1'b0, w_n} : CW'(WIDTH);
        end else if (io_alu.start) begin
          r_alu_out <= w_single_res;
          r_zero    <= (w_single_res == '0);
          r_carry   <= (io_alu.alu_op == OP_SLL) ? 1'b0 : w_carry;
          r_ovf     <= (io_alu.alu_op == OP_SLL) ? 1'b0 : w_ovf;
          r_done    <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
        if (!r_is_mul) r_sh <= {r_sh[WIDTH-2:0], 1'b0};
        if (w_last) begin
          r_alu_out <= w_iter_res;
          r_zero    <= (w_iter_res == '0);
          r_carry   <= 1'b0;
          r_ovf     <= w_iter_ovf;
          r_done    <= 1'b1;
        end
      end
    end
  end
endmodule
